llf_queue_scheduler: RTL and testbench

//  Controller for one linked_list_fifo instance. Arbitrates PORTS producer streams onto the

---
 rtl/llf_queue_scheduler_pkg.sv | 17 +
 rtl/llf_queue_scheduler_rr_arbiter.sv | 30 +++
 rtl/llf_queue_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_llf_queue_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/llf_queue_scheduler_pkg.sv
// Shared types and constants for the linked-list FIFO queue scheduler.
package llf_queue_scheduler_pkg;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_INIT  = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   localparam int INIT_EXTRA = 4;

   // The FIFO needs DEPTH cycles to build its free list, plus a few to settle.
   function automatic int init_cycles(input int depth);
      return depth + INIT_EXTRA;
   endfunction

endpackage

// File: rtl/llf_queue_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or after ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic             any
);

   logic found;
   int   idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(ptr) + i) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/llf_queue_scheduler.sv
// Controller for one linked_list_fifo: arbitrates producers onto the push port, drains
// non-empty queues round-robin through a 2-entry skid buffer, and sequences FIFO init.
module llf_queue_scheduler
   import llf_queue_scheduler_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 32,
   parameter int FIFOS      = 8,
   parameter int PORTS      = 4,
   parameter int LOG2_FIFOS = $clog2(FIFOS),
   parameter int LOG2_DEPTH = $clog2(DEPTH),
   parameter int LOG2_PORTS = $clog2(PORTS)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [PORTS-1:0]              in_valid,
   output logic [PORTS-1:0]              in_ready,
   input  logic [PORTS*LOG2_FIFOS-1:0]   in_fifo,
   input  logic [PORTS*WIDTH-1:0]        in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [LOG2_FIFOS-1:0]         out_fifo,
   output logic [WIDTH-1:0]              out_data,
   output logic                          f_rst,
   output logic                          f_push,
   output logic [LOG2_FIFOS-1:0]         f_push_fifo,
   output logic [WIDTH-1:0]              f_d,
   output logic                          f_pop,
   output logic [LOG2_FIFOS-1:0]         f_pop_fifo,
   input  logic [WIDTH-1:0]              f_q,
   output logic [FIFOS-1:0]              q_nonempty,
   output logic                          ready
);

   localparam int CNT_W  = LOG2_DEPTH + 1;
   localparam int INIT_N = init_cycles(DEPTH);
   localparam int INIT_W = $clog2(INIT_N + 1);
   localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(DEPTH - FIFOS);

   state_e                  state_q, state_d;
   logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
   logic                    run;

   logic [CNT_W-1:0]        occ_q [FIFOS];
   logic [CNT_W-1:0]        occ_d [FIFOS];
   logic [CNT_W-1:0]        free_q, free_d;
   logic [LOG2_PORTS-1:0]   push_ptr_q, push_ptr_d, push_idx;
   logic [LOG2_FIFOS-1:0]   pop_ptr_q, pop_ptr_d;
   logic [PORTS-1:0]        push_req;
   logic [FIFOS-1:0]        pop_req, pop_gnt;
   logic                    pop_allow;

   logic                    inflight_vld_q;
   logic [LOG2_FIFOS-1:0]   inflight_fifo_q;
   logic [WIDTH-1:0]        skid_data_q [2];
   logic [LOG2_FIFOS-1:0]   skid_fifo_q [2];
   logic                    skid_wr_q, skid_rd_q, skid_pop;
   logic [1:0]              skid_cnt_q, skid_cnt_d, pend;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_RESET;
         init_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      unique case (state_q)
         ST_RESET: begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
         end
         ST_INIT: begin
            if (init_cnt_q == INIT_W'(INIT_N - 1)) state_d = ST_RUN;
            else init_cnt_d = init_cnt_q + INIT_W'(1);
         end
         ST_RUN:  ;
         default: state_d = ST_RESET;
      endcase
   end

   assign run   = (state_q == ST_RUN);
   assign ready = run;
   assign f_rst = (state_q == ST_RESET) || ((state_q == ST_INIT) && (init_cnt_q == '0));

   always_comb begin
      for (int q = 0; q < FIFOS; q++) q_nonempty[q] = (occ_q[q] != '0);
   end

   // Pop decisions use registered occupancy only, so a fresh push is poppable next cycle.
   assign pend      = skid_cnt_q + {1'b0, inflight_vld_q};
   assign pop_allow = run && (pend < 2'd2);
   assign push_req  = in_valid & {PORTS{run && (free_q != '0)}};
   assign pop_req   = q_nonempty & {FIFOS{pop_allow}};

   rr_arbiter #(.N(PORTS), .PTR_W(LOG2_PORTS)) u_push_arb (
      .req(push_req), .ptr(push_ptr_q), .gnt(in_ready), .any(f_push)
   );

   rr_arbiter #(.N(FIFOS), .PTR_W(LOG2_FIFOS)) u_pop_arb (
      .req(pop_req), .ptr(pop_ptr_q), .gnt(pop_gnt), .any(f_pop)
   );

   always_comb begin
      f_push_fifo = '0;
      f_d         = '0;
      push_idx    = '0;
      for (int p = 0; p < PORTS; p++) begin
         if (in_ready[p]) begin
            f_push_fifo = in_fifo[p*LOG2_FIFOS +: LOG2_FIFOS];
            f_d         = in_data[p*WIDTH +: WIDTH];
            push_idx    = LOG2_PORTS'(p);
         end
      end
      f_pop_fifo = '0;
      for (int q = 0; q < FIFOS; q++) begin
         if (pop_gnt[q]) f_pop_fifo = LOG2_FIFOS'(q);
      end
   end

   always_comb begin
      push_ptr_d = push_ptr_q;
      if (f_push) push_ptr_d = (push_idx == LOG2_PORTS'(PORTS - 1)) ? '0 : push_idx + LOG2_PORTS'(1);
      pop_ptr_d = pop_ptr_q;
      if (f_pop) pop_ptr_d = (f_pop_fifo == LOG2_FIFOS'(FIFOS - 1)) ? '0 : f_pop_fifo + LOG2_FIFOS'(1);
      for (int q = 0; q < FIFOS; q++) begin
         occ_d[q] = occ_q[q];
         if (f_push && (f_push_fifo == LOG2_FIFOS'(q)) && !(f_pop && (f_pop_fifo == LOG2_FIFOS'(q))))
            occ_d[q] = occ_q[q] + CNT_W'(1);
         else if (f_pop && (f_pop_fifo == LOG2_FIFOS'(q)) && !(f_push && (f_push_fifo == LOG2_FIFOS'(q))))
            occ_d[q] = occ_q[q] - CNT_W'(1);
      end
      unique case ({f_push, f_pop})
         2'b10:   free_d = free_q - CNT_W'(1);
         2'b01:   free_d = free_q + CNT_W'(1);
         default: free_d = free_q;
      endcase
   end

   assign out_valid = run && (skid_cnt_q != 2'd0);
   assign out_fifo  = skid_fifo_q[skid_rd_q];
   assign out_data  = skid_data_q[skid_rd_q];
   assign skid_pop  = out_valid && out_ready;

   always_comb begin
      unique case ({inflight_vld_q, skid_pop})
         2'b10:   skid_cnt_d = skid_cnt_q + 2'd1;
         2'b01:   skid_cnt_d = skid_cnt_q - 2'd1;
         default: skid_cnt_d = skid_cnt_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int q = 0; q < FIFOS; q++) occ_q[q] <= '0;
         free_q          <= CAPACITY;
         push_ptr_q      <= '0;
         pop_ptr_q       <= '0;
         inflight_vld_q  <= 1'b0;
         inflight_fifo_q <= '0;
         skid_wr_q       <= 1'b0;
         skid_rd_q       <= 1'b0;
         skid_cnt_q      <= '0;
         for (int i = 0; i < 2; i++) begin
            skid_data_q[i] <= '0;
            skid_fifo_q[i] <= '0;
         end
      end else begin
         occ_q           <= occ_d;
         free_q          <= free_d;
         push_ptr_q      <= push_ptr_d;
         pop_ptr_q       <= pop_ptr_d;
         inflight_vld_q  <= f_pop;
         inflight_fifo_q <= f_pop_fifo;
         // f_q belongs to the pop issued last cycle; capture it with its queue id.
         if (inflight_vld_q) begin
            skid_data_q[skid_wr_q] <= f_q;
            skid_fifo_q[skid_wr_q] <= inflight_fifo_q;
         end
         skid_wr_q  <= skid_wr_q ^ inflight_vld_q;
         skid_rd_q  <= skid_rd_q ^ skid_pop;
         skid_cnt_q <= skid_cnt_d;
      end
   end

endmodule

// File: tb/tb_llf_queue_scheduler.sv
// Bench for llf_queue_scheduler: FIFO stand-in, queue-level reference model, directed scenarios.
module tb_llf_queue_scheduler;

   localparam int WIDTH = 8, DEPTH = 32, FIFOS = 8, PORTS = 4, LF = 3, LP = 2;

   logic                clk = 1'b0;
   logic                rst;
   logic [PORTS-1:0]    in_valid;
   logic [PORTS-1:0]    in_ready;
   logic [PORTS*LF-1:0] in_fifo;
   logic [PORTS*WIDTH-1:0] in_data;
   logic                out_valid, out_ready;
   logic [LF-1:0]       out_fifo;
   logic [WIDTH-1:0]    out_data;
   logic                f_rst, f_push, f_pop;
   logic [LF-1:0]       f_push_fifo, f_pop_fifo;
   logic [WIDTH-1:0]    f_d;
   logic [WIDTH-1:0]    f_q = '0;
   logic [FIFOS-1:0]    q_nonempty;
   logic                ready;

   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   llf_queue_scheduler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FIFOS(FIFOS), .PORTS(PORTS)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_fifo(in_fifo),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_fifo(out_fifo),
      .out_data(out_data), .f_rst(f_rst), .f_push(f_push), .f_push_fifo(f_push_fifo),
      .f_d(f_d), .f_pop(f_pop), .f_pop_fifo(f_pop_fifo), .f_q(f_q),
      .q_nonempty(q_nonempty), .ready(ready)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Linked-list FIFO stand-in: per-queue storage, read data one cycle after f_pop.
   logic [WIDTH-1:0] mem_q [FIFOS][$];
   always @(posedge clk) begin
      if (f_rst) begin
         for (int q = 0; q < FIFOS; q++) mem_q[q].delete();
      end else begin
         if (f_pop) begin
            chk("fifo_pop_nonempty", 32'(mem_q[f_pop_fifo].size() != 0), 32'(1));
            if (mem_q[f_pop_fifo].size() != 0) f_q <= mem_q[f_pop_fifo].pop_front();
         end
         if (f_push) mem_q[f_push_fifo].push_back(f_d);
      end
   end

   // Reference model: state phase, pointers, occupancy, per-queue contents, output pipeline.
   int               m_st, m_init, m_pptr, m_qptr, m_free;
   int               m_occ [FIFOS];
   logic [WIDTH-1:0] m_qd [FIFOS][$];
   bit               m_if_v, n_if_v;
   int               m_if_q, n_if_q;
   logic [WIDTH-1:0] m_if_d, n_if_d;
   int               sk_f[$];
   logic [WIDTH-1:0] sk_d[$];
   bit               e_run, e_xfer;
   int               e_gp, e_gq, e_p, e_q, e_pf;
   logic [PORTS-1:0] e_ir;
   logic [FIFOS-1:0] e_ne;

   task automatic m_reset();
      m_st = 0; m_init = 0; m_pptr = 0; m_qptr = 0; m_free = DEPTH - FIFOS;
      for (int q = 0; q < FIFOS; q++) begin m_occ[q] = 0; m_qd[q].delete(); end
      m_if_v = 0; m_if_q = 0; m_if_d = '0;
      sk_f.delete(); sk_d.delete();
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         m_reset();
         chk("rst_in_ready", 32'(in_ready), 32'(0));
         chk("rst_out_valid", 32'(out_valid), 32'(0));
         chk("rst_out_fifo", 32'(out_fifo), 32'(0));
         chk("rst_out_data", 32'(out_data), 32'(0));
         chk("rst_f_push", 32'(f_push), 32'(0));
         chk("rst_f_pop", 32'(f_pop), 32'(0));
         chk("rst_f_rst", 32'(f_rst), 32'(1));
         chk("rst_q_nonempty", 32'(q_nonempty), 32'(0));
         chk("rst_ready", 32'(ready), 32'(0));
      end else begin
         e_run = (m_st == 2);
         e_gp = -1;
         if (e_run && m_free != 0)
            for (int k = 0; k < PORTS; k++) begin
               e_p = (m_pptr + k) % PORTS;
               if (e_gp < 0 && in_valid[e_p]) e_gp = e_p;
            end
         e_gq = -1;
         if (e_run && (sk_f.size() + (m_if_v ? 1 : 0)) < 2)
            for (int k = 0; k < FIFOS; k++) begin
               e_q = (m_qptr + k) % FIFOS;
               if (e_gq < 0 && m_occ[e_q] != 0) e_gq = e_q;
            end
         e_ir = '0;
         if (e_gp >= 0) e_ir[e_gp] = 1'b1;
         for (int q = 0; q < FIFOS; q++) e_ne[q] = (m_occ[q] != 0);

         chk("ready", 32'(ready), 32'(e_run));
         chk("f_rst", 32'(f_rst), 32'(m_st == 0 || (m_st == 1 && m_init == 0)));
         chk("in_ready", 32'(in_ready), 32'(e_ir));
         chk("f_push", 32'(f_push), 32'(e_gp >= 0));
         if (e_gp >= 0) begin
            chk("f_push_fifo", 32'(f_push_fifo), 32'(in_fifo[e_gp*LF +: LF]));
            chk("f_d", 32'(f_d), 32'(in_data[e_gp*WIDTH +: WIDTH]));
         end
         chk("f_pop", 32'(f_pop), 32'(e_gq >= 0));
         if (e_gq >= 0) chk("f_pop_fifo", 32'(f_pop_fifo), 32'(e_gq));
         chk("q_nonempty", 32'(q_nonempty), 32'(e_ne));
         chk("out_valid", 32'(out_valid), 32'(e_run && sk_f.size() > 0));
         if (e_run && sk_f.size() > 0) begin
            chk("out_fifo", 32'(out_fifo), 32'(sk_f[0]));
            chk("out_data", 32'(out_data), 32'(sk_d[0]));
         end

         if (m_st == 0) begin m_st = 1; m_init = 0; end
         else if (m_st == 1) begin
            if (m_init == DEPTH + 3) m_st = 2;
            else m_init++;
         end
         e_xfer = e_run && sk_f.size() > 0 && out_ready;
         n_if_v = 0; n_if_q = 0; n_if_d = '0;
         if (e_gq >= 0) begin
            n_if_v = 1; n_if_q = e_gq;
            n_if_d = m_qd[e_gq].pop_front();
            m_occ[e_gq]--; m_free++;
            m_qptr = (e_gq + 1) % FIFOS;
         end
         if (e_gp >= 0) begin
            e_pf = int'(in_fifo[e_gp*LF +: LF]);
            m_qd[e_pf].push_back(in_data[e_gp*WIDTH +: WIDTH]);
            m_occ[e_pf]++; m_free--;
            m_pptr = (e_gp + 1) % PORTS;
         end
         if (e_xfer) begin void'(sk_f.pop_front()); void'(sk_d.pop_front()); end
         if (m_if_v) begin sk_f.push_back(m_if_q); sk_d.push_back(m_if_d); end
         m_if_v = n_if_v; m_if_q = n_if_q; m_if_d = n_if_d;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int               rise, frst_cnt, early, n, acc, gi;
   int               gseq [8];
   int               gcnt [PORTS];
   int               got_f [6];
   logic [WIDTH-1:0] got_d [6];
   int               exp_pf [6] = '{1, 5, 6, 1, 5, 6};
   logic [WIDTH-1:0] exp_pd [6] = '{8'h11, 8'h51, 8'h61, 8'h12, 8'h52, 8'h62};
   bit               stall_v;
   logic [LF-1:0]    st_f;
   logic [WIDTH-1:0] st_d;

   initial begin
      rst = 1'b0; in_valid = '0; in_fifo = '0; in_data = '0; out_ready = 1'b1;

      // Init sequence.
      repeat (3) step();
      rst = 1'b1;
      rise = -1; frst_cnt = 0; early = 0;
      for (int i = 1; i <= 60 && rise < 0; i++) begin
         @(posedge clk); #1;
         if (f_rst) frst_cnt++;
         if (!ready && (f_push || f_pop)) early++;
         if (ready) rise = i;
      end
      chk("init_ready_edge", 32'(rise), 32'(37));
      chk("init_frst_cycles", 32'(frst_cnt), 32'(1));
      chk("init_no_early_ops", 32'(early), 32'(0));

      // Pop fairness with toggling backpressure.
      out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         in_valid = 4'b0001;
         in_fifo[LF-1:0]    = LF'(exp_pf[i]);
         in_data[WIDTH-1:0] = exp_pd[i];
         step();
      end
      in_valid = '0;
      n = 0; stall_v = 0;
      for (int c = 0; c < 40 && n < 6; c++) begin
         out_ready = (c % 2 == 1);
         @(negedge clk);
         if (stall_v)
            chk("stall_stable", 32'({out_valid, out_fifo, out_data}), 32'({1'b1, st_f, st_d}));
         stall_v = out_valid && !out_ready; st_f = out_fifo; st_d = out_data;
         if (out_valid && out_ready) begin got_f[n] = int'(out_fifo); got_d[n] = out_data; n++; end
         step();
      end
      chk("popfair_count", 32'(n), 32'(6));
      for (int i = 0; i < 6; i++) begin
         chk("popfair_fifo", 32'(got_f[i]), 32'(exp_pf[i]));
         chk("popfair_data", 32'(got_d[i]), 32'(exp_pd[i]));
      end
      out_ready = 1'b1;
      repeat (5) step();

      // Push-to-output latency.
      in_valid = 4'b0001; in_fifo[LF-1:0] = 3'd3; in_data[WIDTH-1:0] = 8'hA5;
      @(negedge clk);
      chk("lat_grant", 32'(in_ready), 32'(4'b0001));
      step();
      in_valid = '0;
      @(negedge clk);
      chk("lat_f_pop", 32'(f_pop), 32'(1));
      chk("lat_f_pop_fifo", 32'(f_pop_fifo), 32'(3));
      step();
      @(negedge clk);
      chk("lat_early_out", 32'(out_valid), 32'(0));
      step();
      @(negedge clk);
      chk("lat_out_valid", 32'(out_valid), 32'(1));
      chk("lat_out_fifo", 32'(out_fifo), 32'(3));
      chk("lat_out_data", 32'(out_data), 32'(8'hA5));
      repeat (3) step();

      // Push fairness: one port-3 push realigns the pointer to port 0.
      in_valid = 4'b1000;
      step();
      in_valid = 4'b1111;
      for (int p = 0; p < PORTS; p++) gcnt[p] = 0;
      for (int i = 0; i < 8; i++) begin
         in_fifo = PORTS*LF'($urandom); in_data = $urandom;
         @(negedge clk);
         gi = -1;
         for (int k = 0; k < PORTS; k++) if (in_ready[k]) gi = k;
         gseq[i] = gi;
         if (gi >= 0) gcnt[gi]++;
         step();
      end
      in_valid = '0;
      for (int i = 0; i < 8; i++) chk("pushfair_order", 32'(gseq[i]), 32'(i % 4));
      for (int p = 0; p < PORTS; p++) chk("pushfair_count", 32'(gcnt[p]), 32'(2));
      repeat (20) step();

      // Randomized traffic in three backpressure regimes.
      for (int seg = 0; seg < 3; seg++) begin
         for (int i = 0; i < 500; i++) begin
            in_valid = PORTS'($urandom); in_fifo = PORTS*LF'($urandom); in_data = $urandom;
            case (seg)
               0:       out_ready = ($urandom % 4) != 0;
               1:       out_ready = ($urandom % 8) == 0;
               default: out_ready = ($urandom % 2) != 0;
            endcase
            step();
         end
      end
      in_valid = '0; out_ready = 1'b1;
      repeat (60) step();
      chk("drain_nonempty", 32'(q_nonempty), 32'(0));
      chk("drain_free", 32'(dut.free_q), 32'(24));

      // Capacity: FIFO plus two skid words.
      out_ready = 1'b0; in_valid = 4'b0001; acc = 0;
      for (int i = 0; i < 40; i++) begin
         in_fifo = PORTS*LF'($urandom); in_data = $urandom;
         @(negedge clk);
         if (in_valid[0] && in_ready[0]) acc++;
         step();
      end
      chk("cap_accepted", 32'(acc), 32'(26));
      chk("cap_in_ready", 32'(in_ready), 32'(0));
      out_ready = 1'b1;
      @(negedge clk);
      chk("cap_out_valid", 32'(out_valid), 32'(1));
      step();
      out_ready = 1'b0; acc = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_valid[0] && in_ready[0]) acc++;
         step();
      end
      chk("cap_one_more", 32'(acc), 32'(1));

      // Reset with full skid buffer.
      in_valid = '0;
      rst = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(out_valid), 32'(0));
      chk("midrst_f_rst", 32'(f_rst), 32'(1));
      repeat (3) step();
      rst = 1'b1; out_ready = 1'b1;
      repeat (40) step();
      chk("reinit_ready", 32'(ready), 32'(1));
      chk("reinit_nonempty", 32'(q_nonempty), 32'(0));
      chk("reinit_free", 32'(dut.free_q), 32'(24));
      chk("reinit_model_free", 32'(m_free), 32'(24));

      for (int i = 0; i < 200; i++) begin
         in_valid = PORTS'($urandom); in_fifo = PORTS*LF'($urandom); in_data = $urandom;
         out_ready = ($urandom % 3) != 0;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
